uart_rx_frontend: RTL and testbench

Line-side front end of the UART receive path: synchronises the raw serial input, generates the oversampled baud timebase, qualifies start bits, majority-votes each bit and drives the control strobes of the downstream `rx_uart` deserialiser. `rx_uart` consumes `enable`, `clk_handle` and `rx_bit`. This block owns all bit timing; `rx_uart` only counts strobes.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_rx_frontend.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions used by the RX front end, the
//                rx_uart deserialiser and the transmitter: receive front-end
//                FSM encoding, frame geometry, default oversampling ratio and
//                a 3-input majority helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receive front-end states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        RX_FE_IDLE      = 3'd0,
        RX_FE_START_CHK = 3'd1,
        RX_FE_DATA      = 3'd2,
        RX_FE_STOP      = 3'd3,
        RX_FE_WAIT_HIGH = 3'd4
    } rx_fe_state_t;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_FRAME_SLOTS        = 10;  // start + 8 data + stop
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Oversampling timebase. Counts 0..DIV-1 and flags os_tick in
//                the last count of each period. A synchronous clear restarts
//                the period with the clearing cycle itself taken as count 0,
//                so the tick phase is locked to the event that caused it.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-low reset
//                clear   - synchronous period restart
//                os_tick - high for one cycle at count DIV-1
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic os_tick
);

    localparam int             CW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  c_last = CW'(DIV - 1);
    localparam logic [CW-1:0]  c_one  = CW'(1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            // The clearing cycle counts as phase 0.
            r_cnt <= c_one;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign os_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frontend
//  Description : Line-side UART receive front end. Synchronises rx_line,
//                aligns the oversampled timebase to the start edge, qualifies
//                the start bit, majority-votes every bit around mid-bit and
//                drives the enable / clk_handle / rx_bit strobes of rx_uart.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-low reset
//                rx_line    - raw serial input, idle high
//                enable     - pulse: start bit confirmed
//                clk_handle - pulse per bit slot (10 per frame)
//                rx_bit     - voted bit, valid with clk_handle
//                frame_err  - pulse: stop bit voted 0 (with clk_handle #10)
//                busy       - frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_line,
    output logic enable,
    output logic clk_handle,
    output logic rx_bit,
    output logic frame_err,
    output logic busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_FRAME_SLOTS);

    localparam logic [SW-1:0] c_sub_last  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] c_sub_lo    = SW'(M - 1);
    localparam logic [SW-1:0] c_sub_mid   = SW'(M);
    localparam logic [SW-1:0] c_sub_vote  = SW'(M + 1);
    localparam logic [SW-1:0] c_sub_start = SW'(M + 2);
    localparam logic [BW-1:0] c_bit_data  = BW'(UART_DATA_BITS);
    localparam logic [BW-1:0] c_bit_last  = BW'(UART_FRAME_SLOTS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_frontend: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 8) begin : g_os_chk
        $error("uart_rx_frontend: OVERSAMPLE must be >= 8");
    end

    // Input synchroniser plus one extra stage for edge detection.
    logic r_sync1, r_sync2, r_sync3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rx_line;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    rx_fe_state_t   r_state;
    logic [SW-1:0]  r_sub;
    logic [BW-1:0]  r_bitn;
    logic           r_s_lo, r_s_mid;
    logic           r_start_ok;

    logic w_fall, w_clear, w_tick, w_vote_now, w_vote;

    assign w_fall     = r_sync3 & ~r_sync2;
    assign w_clear    = (r_state == RX_FE_IDLE) & w_fall;
    assign w_vote_now = w_tick & (r_sub == c_sub_vote);
    // Third sample is the live synced line at the vote tick.
    assign w_vote     = maj3(r_s_lo, r_s_mid, r_sync2);

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .os_tick (w_tick)
    );

    // Sub-tick / bit counters and the two early mid-bit samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sub   <= '0;
            r_bitn  <= '0;
            r_s_lo  <= 1'b1;
            r_s_mid <= 1'b1;
        end else if (w_clear) begin
            r_sub  <= '0;
            r_bitn <= '0;
        end else if (w_tick) begin
            if (r_sub == c_sub_last) begin
                r_sub  <= '0;
                r_bitn <= (r_bitn == c_bit_last) ? '0 : r_bitn + 1'b1;
            end else begin
                r_sub <= r_sub + 1'b1;
            end
            if (r_sub == c_sub_lo)  r_s_lo  <= r_sync2;
            if (r_sub == c_sub_mid) r_s_mid <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RX_FE_IDLE;
            r_start_ok <= 1'b0;
            enable     <= 1'b0;
            clk_handle <= 1'b0;
            rx_bit     <= 1'b1;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            enable     <= 1'b0;
            clk_handle <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RX_FE_IDLE: begin
                    busy <= 1'b0;
                    if (w_fall) begin
                        r_state    <= RX_FE_START_CHK;
                        r_start_ok <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                RX_FE_START_CHK: begin
                    if (!r_start_ok) begin
                        if (w_vote_now) begin
                            if (w_vote) begin
                                // Glitch: drop back silently.
                                r_state <= RX_FE_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                enable     <= 1'b1;
                                rx_bit     <= 1'b0;
                                r_start_ok <= 1'b1;
                            end
                        end
                    end else if (w_tick && (r_sub == c_sub_start)) begin
                        // Strobe #1 trails enable by one sub-tick.
                        clk_handle <= 1'b1;
                        r_state    <= RX_FE_DATA;
                    end
                end
                RX_FE_DATA: begin
                    if (w_vote_now) begin
                        rx_bit     <= w_vote;
                        clk_handle <= 1'b1;
                        if (r_bitn == c_bit_data) r_state <= RX_FE_STOP;
                    end
                end
                RX_FE_STOP: begin
                    if (w_vote_now) begin
                        rx_bit     <= w_vote;
                        clk_handle <= 1'b1;
                        if (w_vote) begin
                            // Re-armed at mid-stop so a back-to-back start
                            // edge is not missed.
                            r_state <= RX_FE_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= RX_FE_WAIT_HIGH;
                        end
                    end
                end
                RX_FE_WAIT_HIGH: begin
                    // A held-low line must not be taken as a new start.
                    if (r_sync2) begin
                        r_state <= RX_FE_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RX_FE_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frontend
//  Description : Directed self-checking bench for uart_rx_frontend with a
//                behavioural rx_uart stand-in that rebuilds bytes from the
//                clk_handle / rx_bit strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_frontend;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT      = 160;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic rx_line = 1'b1;
    logic enable, clk_handle, rx_bit, frame_err, busy;

    uart_rx_frontend #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (rx_line),
        .enable     (enable),
        .clk_handle (clk_handle),
        .rx_bit     (rx_bit),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream model: counts strobes and deserialises LSB first.
    int         n_en = 0, n_ch = 0, n_fe = 0, n_coinc = 0, n_bytes = 0;
    int         slot = 0, en_cyc = 0, ch1_cyc = 0, fe_slot = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] bytes [0:7];
    logic       stops [0:7];

    always @(negedge clk) begin
        if (enable) begin
            n_en++;
            slot   = 0;
            en_cyc = cyc;
            if (clk_handle) n_coinc++;
        end
        if (clk_handle) begin
            n_ch++;
            slot++;
            if (slot == 1) ch1_cyc = cyc;
            if (slot >= 2 && slot <= 9) sh = {rx_bit, sh[7:1]};
            if (slot == 10) begin
                bytes[n_bytes % 8] = sh;
                stops[n_bytes % 8] = rx_bit;
                n_bytes++;
            end
        end
        if (frame_err) begin
            n_fe++;
            fe_slot = clk_handle ? slot : -1;
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame cycle by cycle; after the stop bit the line holds the
    // stop value for `tail` cycles. Raw cycles inv_lo..inv_hi are inverted.
    // At raw cycle rst_at reset is pulsed low for 5 cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int tail,
                              input int inv_lo, input int inv_hi, input int rst_at,
                              output int r0);
        logic [9:0] bits;
        logic       b;
        bits = {stop, d, 1'b0};
        r0   = cyc;
        for (int i = 0; i < 10 * BIT + tail; i++) begin
            b = (i < 10 * BIT) ? bits[i / BIT] : stop;
            if (i >= inv_lo && i <= inv_hi) b = ~b;
            rx_line = b;
            if (i == rst_at) begin
                check("busy_before_rst", busy, 1);
                rst = 1'b0;
                #1;
                check("rst_enable", enable, 0);
                check("rst_clk_handle", clk_handle, 0);
                check("rst_rx_bit", rx_bit, 1);
                check("rst_frame_err", frame_err, 0);
                check("rst_busy", busy, 0);
            end
            if (i == rst_at + 5) rst = 1'b1;
            tick(1);
        end
    endtask

    int r, e0, c0, f0, b0;

    initial begin
        // Reset state
        tick(3);
        check("reset_enable", enable, 0);
        check("reset_clk_handle", clk_handle, 0);
        check("reset_rx_bit", rx_bit, 1);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        tick(20);

        // Frame 0xA5
        e0 = n_en; c0 = n_ch; f0 = n_fe; b0 = n_bytes;
        send_frame(8'hA5, 1'b1, 100, -1, -1, -1, r);
        check("a5_enable_cnt", n_en - e0, 1);
        check("a5_strobe_cnt", n_ch - c0, 10);
        check("a5_no_ferr", n_fe - f0, 0);
        check("a5_byte", bytes[b0 % 8], 8'hA5);
        check("a5_stop", stops[b0 % 8], 1);
        check("a5_enable_time", en_cyc - r, 102);
        check("a5_ch1_gap", ch1_cyc - en_cyc, 10);
        check("a5_busy_end", busy, 0);

        // 40-cycle glitch, then 0x3C
        e0 = n_en; c0 = n_ch;
        for (int i = 0; i < 200; i++) begin
            rx_line = (i < 40) ? 1'b0 : 1'b1;
            if (i == 95)  check("glitch_busy_hi", busy, 1);
            if (i == 115) check("glitch_busy_lo", busy, 0);
            tick(1);
        end
        check("glitch_no_enable", n_en - e0, 0);
        check("glitch_no_strobe", n_ch - c0, 0);
        b0 = n_bytes;
        send_frame(8'h3C, 1'b1, 100, -1, -1, -1, r);
        check("3c_byte", bytes[b0 % 8], 8'h3C);

        // 0x00 with stop held low, line high 300 cycles later
        e0 = n_en; c0 = n_ch; f0 = n_fe; b0 = n_bytes;
        send_frame(8'h00, 1'b0, 300, -1, -1, -1, r);
        check("ferr_strobe_cnt", n_ch - c0, 10);
        check("ferr_cnt", n_fe - f0, 1);
        check("ferr_slot", fe_slot, 10);
        check("ferr_byte", bytes[b0 % 8], 8'h00);
        check("ferr_stop", stops[b0 % 8], 0);
        check("ferr_busy_held", busy, 1);
        rx_line = 1'b1;
        tick(10);
        check("ferr_busy_release", busy, 0);
        tick(300);
        check("ferr_no_spurious", n_en - e0, 1);

        // Back-to-back 0x55, 0xFF
        e0 = n_en; c0 = n_ch; b0 = n_bytes;
        send_frame(8'h55, 1'b1, 0, -1, -1, -1, r);
        send_frame(8'hFF, 1'b1, 100, -1, -1, -1, r);
        check("b2b_enable_cnt", n_en - e0, 2);
        check("b2b_strobe_cnt", n_ch - c0, 20);
        check("b2b_byte0", bytes[b0 % 8], 8'h55);
        check("b2b_byte1", bytes[(b0 + 1) % 8], 8'hFF);

        // Sub-sample 7 of data bit 3 inverted for one DIV window
        b0 = n_bytes;
        send_frame(8'hC3, 1'b1, 100, 550, 559, -1, r);
        check("vote_byte", bytes[b0 % 8], 8'hC3);

        // Reset during bit 4 of a 0xFF frame, then 0x81
        e0 = n_en; c0 = n_ch; b0 = n_bytes;
        send_frame(8'hFF, 1'b1, 200, -1, -1, 4 * BIT + 80, r);
        check("rst_enable_cnt", n_en - e0, 1);
        check("rst_strobe_cnt", n_ch - c0, 4);
        check("rst_no_byte", n_bytes - b0, 0);
        b0 = n_bytes;
        send_frame(8'h81, 1'b1, 100, -1, -1, -1, r);
        check("81_byte", bytes[b0 % 8], 8'h81);
        check("81_stop", stops[b0 % 8], 1);

        check("no_coincident_strobes", n_coinc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
